nco_freq_meter: RTL and testbench
=================================

Name: nco_freq_meter

Overview:
Receive-side counterpart to the nco block. It consumes a stream of signed sine samples, such as an nco sine_out looped back or a digitised IF tone, and detects rising zero crossings with hysteresis. It counts samples over 2^CYCLES_LOG2 full cycles, then runs a bit-serial divider to recover the equivalent phase_increment word. Used for built-in self-test of the chirp/NCO path and for calibrating the IF tone frequency.

Parameters:
PHASE_WIDTH, 32, width of the recovered phase-increment word; matches the NCO accumulator.
DATA_WIDTH, 12, width of the signed input sample; matches the NCO output.
CYCLES_LOG2, 2, log2 of the number of input cycles averaged per estimate (default 4 cycles).
CNT_WIDTH, 20, width of the sample counter; it also sets the timeout limit.
HYST, 16, hysteresis threshold in LSBs, positive, less than 2^(DATA_WIDTH-1).

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-high reset.
sample_valid  in  1  qualifies sample_in; can be deasserted for any number of cycles.
sample_in  in  DATA_WIDTH  signed two's-complement sample.
busy  out  1  high in the MEASURE and DIVIDE states.
phase_inc_est  out  PHASE_WIDTH  last completed estimate; held until the next one completes.
est_valid  out  1  one-cycle pulse when phase_inc_est updates.
timeout  out  1  one-cycle pulse when a measurement is abandoned.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; armed = 0; counter = 0.
  - busy = 0, phase_inc_est = 0, est_valid = 0, timeout = 0.
  - Reset during MEASURE or DIVIDE aborts the operation; no partial result appears.
- Crossing detector: updates only on clocks with sample_valid = 1, and runs in every state.
  - The armed flag is set when sample_in <= -HYST.
  - A crossing event occurs when armed = 1 and sample_in >= 0. The event clears armed in the same clock.
  - Samples strictly between -HYST and 0 leave armed unchanged.
  - A crossing needs at least 2 samples per cycle.
- FSM states: IDLE, MEASURE, DIVIDE, DONE.
- IDLE:
  - On a crossing event, counter <= 0 and crossings <= 0, then go to MEASURE.
  - Crossings are ignored in DIVIDE and DONE.
- MEASURE:
  - On each valid sample, counter <= counter + 1. The sample that is the crossing is included in the count.
  - On a crossing event, crossings++. When crossings reaches 2^CYCLES_LOG2, latch the divisor D = counter + 1 and go to DIVIDE.
  - Timeout: if counter would increment past 2^CNT_WIDTH - 1 before completion, pulse timeout for one clock and return to IDLE. phase_inc_est keeps its previous value.
  - A crossing and the counter limit in the same clock: the crossing wins.
- DIVIDE: restoring bit-serial division.
  - Numerator = 2^(PHASE_WIDTH + CYCLES_LOG2); divisor = D, zero-extended.
  - One quotient bit per clock, MSB first, for N = PHASE_WIDTH + CYCLES_LOG2 + 1 clocks.
  - The quotient is truncated (floor). Its upper CYCLES_LOG2 + 1 bits are provably zero because D >= 2 * 2^CYCLES_LOG2. The low PHASE_WIDTH bits are the result.
  - sample_valid activity during DIVIDE does not affect the result.
- DONE, one clock:
  - phase_inc_est <= quotient; est_valid = 1; busy = 0 from the next clock; return to IDLE.
- Latency: est_valid is high in clock N + 1 after the clock in which the final crossing sample is accepted. At the defaults, N = 35, so est_valid is high 36 clocks later.
- After DONE or a timeout, the next estimate needs a fresh IDLE crossing. Back-to-back windows do not share a crossing.
- est_valid and timeout are never high together.
- busy is a registered output: 1 from the clock after the IDLE→MEASURE transition until DONE or timeout.

Test Plan:
1. Square-like input: -100 for 5 samples, then +100 for 5 samples, repeated; sample_valid = 1 always. Required: D = 40, phase_inc_est = 2^34 / 40 = 429496729, est_valid 36 clocks after the 5th rising crossing, busy = 1 throughout.
2. Loopback of the nco sine_out, phase_increment = 42949673 (1 MHz at 100 MHz). Required: D = 400, phase_inc_est = 42949672. A second estimate then follows on a fresh crossing with the same value.
3. Stimulus 1 with sample_valid toggling every other clock. Required: same result, 429496729; est_valid latency is still 36 clocks after the final accepted sample.
4. Noise within ±5 LSB around 0, HYST = 16, 10000 clocks. Required: no crossing, busy = 0, est_valid and timeout never pulse.
5. CNT_WIDTH = 8; one crossing, then a constant +50. Required: timeout pulses once when the counter saturates at 255 valid samples; state returns to IDLE; phase_inc_est is unchanged from its prior value.
6. rst asserted mid-DIVIDE for 1 clock, with no setup/hold alignment. Required: all outputs are 0 immediately; no est_valid; a subsequent run of stimulus 1 yields 429496729.

Source files
------------

// File: rtl/nco_freq_meter.sv
// Measures the frequency of a signed tone by timing 2^CYCLES_LOG2 rising zero crossings and
// dividing them back into the equivalent NCO phase-increment word.
module nco_freq_meter #(
    parameter int PHASE_WIDTH = 32,
    parameter int DATA_WIDTH  = 12,
    parameter int CYCLES_LOG2 = 2,
    parameter int CNT_WIDTH   = 20,
    parameter int HYST        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_valid,
    input  logic signed [DATA_WIDTH-1:0]  sample_in,
    output logic                          busy,
    output logic [PHASE_WIDTH-1:0]        phase_inc_est,
    output logic                          est_valid,
    output logic                          timeout
);

    localparam int N       = PHASE_WIDTH + CYCLES_LOG2 + 1;
    localparam int STEP_W  = $clog2(N);
    localparam int CROSS_W = CYCLES_LOG2 + 1;

    localparam logic signed [DATA_WIDTH-1:0] NEG_HYST   = DATA_WIDTH'(-HYST);
    localparam logic [CNT_WIDTH-1:0]         CNT_MAX    = '1;
    localparam logic [CROSS_W-1:0]           CROSS_LAST = CROSS_W'((1 << CYCLES_LOG2) - 1);
    localparam logic [STEP_W-1:0]            STEP_LAST  = STEP_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_DIVIDE,
        S_DONE
    } state_t;

    state_t                   r_state;
    logic                     r_armed;
    logic [CNT_WIDTH-1:0]     r_cnt;
    logic [CROSS_W-1:0]       r_cross;
    logic [CNT_WIDTH:0]       r_div;
    logic [CNT_WIDTH:0]       r_rem;
    logic [PHASE_WIDTH-1:0]   r_quot;
    logic [STEP_W-1:0]        r_step;
    logic                     r_busy;
    logic [PHASE_WIDTH-1:0]   r_est;
    logic                     r_est_valid;
    logic                     r_timeout;

    logic                     w_arm;
    logic                     w_xing;
    logic [CNT_WIDTH+1:0]     w_shift;
    logic [CNT_WIDTH+1:0]     w_diff;
    logic                     w_fits;

    assign w_arm  = sample_valid && (sample_in <= NEG_HYST);
    assign w_xing = sample_valid && r_armed && !sample_in[DATA_WIDTH-1];

    // Numerator is a single 1 followed by zeros, so only the first step shifts in a 1.
    assign w_shift = {r_rem, (r_step == '0)};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_fits  = (w_shift >= {1'b0, r_div});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed <= 1'b0;
        end else if (w_arm) begin
            r_armed <= 1'b1;
        end else if (w_xing) begin
            r_armed <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cross     <= '0;
            r_div       <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_step      <= '0;
            r_busy      <= 1'b0;
            r_est       <= '0;
            r_est_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_est_valid <= 1'b0;
            r_timeout   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xing) begin
                        r_cnt   <= '0;
                        r_cross <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (sample_valid) begin
                        // A completing crossing takes priority over the counter limit.
                        if (w_xing && (r_cross == CROSS_LAST)) begin
                            r_div   <= {1'b0, r_cnt} + 1'b1;
                            r_rem   <= '0;
                            r_quot  <= '0;
                            r_step  <= '0;
                            r_state <= S_DIVIDE;
                        end else if (r_cnt == CNT_MAX) begin
                            r_timeout <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            if (w_xing) begin
                                r_cross <= r_cross + 1'b1;
                            end
                        end
                    end
                end
                S_DIVIDE: begin
                    // Upper quotient bits are always zero and fall off the top of r_quot.
                    r_rem  <= w_fits ? w_diff[CNT_WIDTH:0] : w_shift[CNT_WIDTH:0];
                    r_quot <= {r_quot[PHASE_WIDTH-2:0], w_fits};
                    r_step <= r_step + 1'b1;
                    if (r_step == STEP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_est       <= r_quot;
                    r_est_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign phase_inc_est = r_est;
    assign est_valid     = r_est_valid;
    assign timeout       = r_timeout;

endmodule

// File: tb/tb_nco_freq_meter.sv
// Bench for nco_freq_meter: a default-width instance plus an 8-bit-counter instance for timeouts.
module tb_nco_freq_meter;

    localparam int LAT = 36;

    typedef struct {
        logic [31:0] val;
        int          due;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sv = 1'b0, sv8 = 1'b0;
    logic signed [11:0] sd = '0, sd8 = '0;
    logic               busy, estv, to, busy8, estv8, to8;
    logic [31:0]        est, est8;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q_est[$];
    exp_t q_est8[$];
    int   q_to8[$];
    exp_t m_e;
    int   m_d;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nco_freq_meter u_dut (
        .clk(clk), .rst(rst), .sample_valid(sv), .sample_in(sd),
        .busy(busy), .phase_inc_est(est), .est_valid(estv), .timeout(to)
    );

    nco_freq_meter #(.CNT_WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .sample_valid(sv8), .sample_in(sd8),
        .busy(busy8), .phase_inc_est(est8), .est_valid(estv8), .timeout(to8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (estv) begin
            if (q_est.size() == 0) begin
                check("est_unexpected", 1, 0);
            end else begin
                m_e = q_est.pop_front();
                check("est_val", est, m_e.val);
                check("est_lat", cyc, m_e.due);
            end
        end
        if (to) check("timeout_unexpected", 1, 0);
        if (estv8) begin
            if (q_est8.size() == 0) begin
                check("est8_unexpected", 1, 0);
            end else begin
                m_e = q_est8.pop_front();
                check("est8_val", est8, m_e.val);
                check("est8_lat", cyc, m_e.due);
            end
        end
        if (to8) begin
            if (q_to8.size() == 0) begin
                check("to8_unexpected", 1, 0);
            end else begin
                m_d = q_to8.pop_front();
                check("to8_lat", cyc, m_d);
            end
        end
        if (estv || to) check("est_to_excl", estv & to, 0);
        if (estv8 || to8) check("est8_to8_excl", estv8 & to8, 0);
    end

    // Inputs change 1 time unit after a rising edge; the next edge accepts them.
    task automatic drive(input bit which, input logic v, input logic signed [11:0] d);
        if (which) begin
            sv8 = v;
            sd8 = d;
        end else begin
            sv = v;
            sd = d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sv  = 1'b0;
        sv8 = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_est(input bit which, input logic [31:0] val);
        exp_t e;
        e.val = val;
        e.due = cyc + 1 + LAT;
        if (which) q_est8.push_back(e);
        else       q_est.push_back(e);
    endtask

    // Five periods of -100 x5 / +100 x5; the fifth rising crossing completes the window.
    task automatic square(input bit which, input bit gap);
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 10; i++) begin
                if (p == 4 && i == 5) push_est(which, 32'd429496729);
                drive(which, 1'b1, (i < 5) ? -12'sd100 : 12'sd100);
                if (gap) drive(which, 1'b0, -12'sd500);
            end
        end
    endtask

    initial begin
        longint ph;
        real    ang;
        int     d;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_est", est, 0);
        check("rst_estv", estv, 0);
        check("rst_to", to, 0);
        check("rst_busy8", busy8, 0);
        check("rst_est8", est8, 0);
        rst = 1'b0;
        idle(2);

        // Square wave, continuous valid
        square(0, 0);
        check("t1_busy_div", busy, 1);
        idle(50);
        check("t1_busy_after", busy, 0);
        check("t1_est_hold", est, 32'd429496729);

        // NCO sine loopback at 1 MHz / 100 MHz; crossings every 100 samples
        ph = 0;
        for (int n = 0; n <= 1000; n++) begin
            ang = 2.0 * 3.14159265358979 * real'(ph) / 4294967296.0;
            d   = $rtoi($floor(2047.0 * $sin(ang) + 0.5));
            if (n == 500 || n == 1000) push_est(0, 32'd42949672);
            drive(0, 1'b1, 12'(d));
            ph = (ph + 64'd42949673) % 64'd4294967296;
        end
        idle(50);
        check("t2_est_hold", est, 32'd42949672);

        // Square wave with valid toggling; invalid cycles carry junk
        square(0, 1);
        idle(50);
        check("t3_est_hold", est, 32'd429496729);

        // Sub-hysteresis noise
        for (int i = 0; i < 10000; i++) begin
            d = int'($urandom_range(10)) - 5;
            drive(0, 1'b1, 12'(d));
            if (i % 500 == 0) check("t4_busy", busy, 0);
        end
        idle(5);

        // Timeout on the 8-bit-counter instance, after a prior good estimate
        square(1, 0);
        idle(50);
        check("t5_prior_est", est8, 32'd429496729);
        drive(1, 1'b1, -12'sd50);
        drive(1, 1'b1, 12'sd50);
        check("t5_busy", busy8, 1);
        for (int k = 1; k <= 300; k++) begin
            if (k == 256) q_to8.push_back(cyc + 1);
            drive(1, 1'b1, 12'sd50);
        end
        idle(5);
        check("t5_est_kept", est8, 32'd429496729);
        check("t5_busy_after", busy8, 0);

        // Asynchronous reset mid-divide
        square(0, 0);
        idle(5);
        check("t6_busy_pre", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_est", est, 0);
        check("t6_rst_estv", estv, 0);
        check("t6_rst_to", to, 0);
        q_est.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(45);
        check("t6_est_zero", est, 0);
        square(0, 0);
        idle(50);
        check("t6_est_after", est, 32'd429496729);

        check("q_est_empty", q_est.size(), 0);
        check("q_est8_empty", q_est8.size(), 0);
        check("q_to8_empty", q_to8.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
